// File: rtl/mem_access_ctrl.sv
// Data-memory stage sequencer: turns loads/stores into req/ack RAM transactions,
// stalls upstream while a transaction is outstanding, and forwards results to MEM/WB.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_rd_en,
    input  logic        in_wr_en,
    input  logic [31:0] in_data,
    input  logic [31:0] in_rs2,
    input  logic        in_reg_we,
    input  logic [4:0]  in_wb_addr,
    output logic        stall,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cap_reg_we;
    logic          mem_op;

    assign mem_op = in_valid & (in_rd_en | in_wr_en);
    assign stall  = ((state == IDLE) & mem_op) | (state == ACCESS);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_reg_we <= 1'b0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        ram_addr   <= in_data;
                        ram_wdata  <= in_rs2;
                        ram_we     <= in_wr_en;
                        wb_addr    <= in_wb_addr;
                        cap_reg_we <= in_reg_we;
                        ram_req    <= 1'b1;
                        cnt        <= '0;
                        wb_valid   <= 1'b0;
                        state      <= ACCESS;
                    end else if (in_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= in_data;
                        wb_we    <= in_reg_we;
                        wb_addr  <= in_wb_addr;
                        wb_err   <= 1'b0;
                    end else begin
                        wb_valid <= 1'b0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (ram_ack) begin
                        // A store reports its address as the write-back value.
                        ram_req  <= 1'b0;
                        wb_data  <= ram_we ? ram_addr : ram_rdata;
                        wb_we    <= cap_reg_we & ~ram_we;
                        wb_err   <= 1'b0;
                        wb_valid <= 1'b1;
                        state    <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        ram_req  <= 1'b0;
                        wb_we    <= 1'b0;
                        wb_err   <= 1'b1;
                        wb_valid <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a write-back scoreboard keyed by
// expected arrival cycle; every cycle is checked for presence/absence of wb_valid.
module tb_mem_access_ctrl;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_data;
        logic        err;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_rd_en, in_wr_en, in_reg_we;
    logic [31:0] in_data, in_rs2;
    logic [4:0]  in_wb_addr;
    logic        stall, ram_req, ram_we, ram_ack;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        wb_valid, wb_we, wb_err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int      tests = 0;
    int      fails = 0;
    int      cyc   = 0;
    int      t0;
    wb_exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rd_en(in_rd_en), .in_wr_en(in_wr_en),
        .in_data(in_data), .in_rs2(in_rs2), .in_reg_we(in_reg_we),
        .in_wb_addr(in_wb_addr), .stall(stall),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_err(wb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic cd, input logic err);
        wb_exp_t e;
        e.cyc = c; e.we = we; e.addr = a; e.data = d; e.chk_data = cd; e.err = err;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_rd_en = 0; in_wr_en = 0; in_reg_we = 0;
        in_data = '0; in_rs2 = '0; in_wb_addr = '0;
    endtask

    // Advance one clock, sample #1 after the edge, and settle the scoreboard.
    task automatic next_cycle();
        wb_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("wb_we", 32'(wb_we), 32'(e.we));
            check("wb_addr", 32'(wb_addr), 32'(e.addr));
            check("wb_err", 32'(wb_err), 32'(e.err));
            if (e.chk_data) check("wb_data", wb_data, e.data);
        end else begin
            check("wb_idle", 32'(wb_valid), 32'd0);
        end
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [31:0] d,
                            input logic [31:0] rs2, input logic [4:0] a, input logic rwe);
        in_valid = 1; in_rd_en = rd; in_wr_en = wr; in_data = d;
        in_rs2 = rs2; in_wb_addr = a; in_reg_we = rwe;
    endtask

    initial begin
        rst = 1; ram_ack = 0; ram_rdata = '0;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 0;

        // Reset state with idle inputs
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rst_stall", 32'(stall), 32'd0);
            check("rst_ram", {ram_req, ram_we, 30'd0}, 32'd0);
            check("rst_addr", ram_addr, 32'd0);
            check("rst_wdata", ram_wdata, 32'd0);
            check("rst_wb", {wb_we, wb_err, wb_addr, 25'd0}, 32'd0);
            check("rst_wbdata", wb_data, 32'd0);
            next_cycle();
        end

        // Back-to-back non-memory ops
        drive_op(0, 0, 32'h11, 32'h0, 5'd5, 1);
        push(cyc + 1, 1, 5'd5, 32'h11, 1, 0);
        #1 check("nm_stall0", 32'(stall), 32'd0);
        next_cycle();
        drive_op(0, 0, 32'h22, 32'h0, 5'd6, 1);
        push(cyc + 1, 1, 5'd6, 32'h22, 1, 0);
        #1 check("nm_stall1", 32'(stall), 32'd0);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Load from 0x100 to x7, ack at T+3
        t0 = cyc;
        drive_op(1, 0, 32'h100, 32'h0, 5'd7, 1);
        push(t0 + 4, 1, 5'd7, 32'hDEADBEEF, 1, 0);
        #1 check("ld_stall_T", 32'(stall), 32'd1);
        next_cycle();
        clear_inputs();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin ram_ack = 1; ram_rdata = 32'hDEADBEEF; end
            #1;
            check("ld_req", 32'(ram_req), 32'd1);
            check("ld_we", 32'(ram_we), 32'd0);
            check("ld_addr", ram_addr, 32'h100);
            check("ld_stall", 32'(stall), 32'd1);
            next_cycle();
        end
        ram_ack = 0; ram_rdata = '0;
        #1;
        check("ld_req_off", 32'(ram_req), 32'd0);
        check("ld_stall_done", 32'(stall), 32'd0);
        next_cycle();
        next_cycle();

        // Store 0xCAFE to 0x200, ack in the first ACCESS cycle
        t0 = cyc;
        drive_op(0, 1, 32'h200, 32'hCAFE, 5'd3, 1);
        push(t0 + 2, 0, 5'd3, 32'h200, 1, 0);
        #1 check("st_stall_T", 32'(stall), 32'd1);
        next_cycle();
        clear_inputs();
        ram_ack = 1;
        #1;
        check("st_req", 32'(ram_req), 32'd1);
        check("st_we", 32'(ram_we), 32'd1);
        check("st_addr", ram_addr, 32'h200);
        check("st_wdata", ram_wdata, 32'hCAFE);
        next_cycle();
        ram_ack = 0;
        next_cycle();

        // Load with no ack: timeout after 4 ACCESS cycles
        t0 = cyc;
        drive_op(1, 0, 32'h300, 32'h0, 5'd9, 1);
        push(t0 + 5, 0, 5'd9, 32'h0, 0, 1);
        next_cycle();
        clear_inputs();
        for (int k = 1; k <= 4; k++) begin
            check("to_req", 32'(ram_req), 32'd1);
            check("to_stall", 32'(stall), 32'd1);
            next_cycle();
        end
        check("to_req_off", 32'(ram_req), 32'd0);
        check("to_stall_done", 32'(stall), 32'd0);
        next_cycle();
        // T+6: back in IDLE, a pass-through op is accepted immediately
        drive_op(0, 0, 32'h33, 32'h0, 5'd4, 1);
        push(cyc + 1, 1, 5'd4, 32'h33, 1, 0);
        #1 check("to_idle_stall", 32'(stall), 32'd0);
        next_cycle();
        clear_inputs();
        next_cycle();

        // Reset during an outstanding load, stray ack afterwards
        drive_op(1, 0, 32'h400, 32'h0, 5'd10, 1);
        next_cycle();
        clear_inputs();
        check("rs_req1", 32'(ram_req), 32'd1);
        next_cycle();
        rst = 1;
        #1 check("rs_req2", 32'(ram_req), 32'd1);
        next_cycle();
        rst = 0;
        ram_ack = 1; ram_rdata = 32'h12345678;
        #1;
        check("rs_req_off", 32'(ram_req), 32'd0);
        check("rs_stall", 32'(stall), 32'd0);
        next_cycle();
        ram_ack = 0;
        for (int i = 0; i < 3; i++) begin
            check("rs_no_req", 32'(ram_req), 32'd0);
            next_cycle();
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data-memory stage of the RISC-V pipeline. It sits between the ALU/MEM pipeline register and the data RAM. It turns each load/store into a req/ack transaction against a variable-latency RAM and stalls upstream stages while the transaction is outstanding. Results go to the MEM/WB register, and non-memory operations pass through with one cycle of latency.

## Interface
- `TIMEOUT`, 16: maximum number of ACCESS cycles waited for `ram_ack` before the access is aborted (≥2).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: an instruction is present from the ALU/MEM register.
- `in_rd_en` in 1: instruction is a load.
- `in_wr_en` in 1: instruction is a store.
- `in_data` in 32: ALU result, used as the memory address or as the pass-through result.
- `in_rs2` in 32: store data.
- `in_reg_we` in 1: instruction writes back to the register file.
- `in_wb_addr` in 5: destination register.
- `stall` out 1: combinational; holds the upstream pipeline registers.
- `ram_req` out 1: RAM request, held until ack or timeout.
- `ram_we` out 1: 1 = write.
- `ram_addr` out 32: RAM address.
- `ram_wdata` out 32: RAM write data.
- `ram_ack` in 1: RAM completion; sampled only in ACCESS.
- `ram_rdata` in 32: read data, valid with `ram_ack`.
- `wb_valid` out 1: result presented to MEM/WB this cycle.
- `wb_we` out 1: register-file write enable.
- `wb_addr` out 5: destination register.
- `wb_data` out 32: write-back data.
- `wb_err` out 1: access aborted by timeout; qualifies `wb_valid`.

## Operation
- Memory op = `in_valid & (in_rd_en | in_wr_en)`. If both enables are set, the op is a store (`in_wr_en` wins).
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- **IDLE, no `in_valid`:** registered `wb_valid` ← 0.
- **IDLE, non-memory op:**
  - next cycle `wb_valid`=1, `wb_data`=`in_data`, `wb_we`=`in_reg_we`, `wb_addr`=`in_wb_addr`, `wb_err`=0.
  - stays in IDLE; back-to-back ops are accepted every cycle.
- **IDLE, memory op:**
  - capture `ram_addr`←`in_data`, `ram_wdata`←`in_rs2`, `ram_we`←`in_wr_en`, plus write-back address and enable.
  - set `ram_req`←1, clear the timeout counter, go to ACCESS.
  - `wb_valid`←0.
- **ACCESS:**
  - the counter increments every cycle.
  - on `ram_ack`: `ram_req`←0; `wb_data`←`ram_rdata` for a load, or the captured address for a store; `wb_err`←0; go to DONE.
  - with no ack and counter = TIMEOUT−1: `ram_req`←0, `wb_err`←1, go to DONE.
- **DONE:**
  - `wb_valid`=1 for exactly this cycle.
  - `wb_we` = captured `in_reg_we` & ~store & ~err; a store or an aborted access never writes the register file.
  - inputs are ignored (the upstream register is loading the next instruction this cycle).
  - unconditional transition to IDLE.
- `stall` = (IDLE & memory op) | ACCESS. It is 0 in DONE.
- `ram_ack` in IDLE or DONE is ignored. The RAM must not ack without a request.
- `ram_addr`, `ram_wdata` and `ram_we` are stable for the whole period `ram_req` is high.

## Timing
- Reset: state IDLE, counter 0. `ram_req`, `ram_we`, `ram_addr`, `ram_wdata`, `wb_valid`, `wb_we`, `wb_addr`, `wb_data` and `wb_err` are all 0. `stall` is 0 unless IDLE sees a memory op.
- Non-memory op accepted at cycle T → `wb_valid` at T+1.
- Memory op accepted at T:
  - `ram_req` is high from T+1.
  - the earliest ack comes at T+1 (same cycle as `req`), giving `wb_valid` at T+2.
  - an ack at T+k gives DONE at T+k+1.
  - `stall` is high from T through the ack cycle.
- Timeout: `req` is high for exactly TIMEOUT cycles, T+1..T+TIMEOUT, and DONE with `wb_err` comes at T+TIMEOUT+1.
- Minimum spacing between two memory ops is 3 cycles (IDLE, ACCESS, DONE).
- Reset asserted mid-access: the next edge returns to IDLE and drops `ram_req`. No `wb_valid` is produced and nothing is retried.

## Test plan
- Reset, then idle inputs → all outputs 0 and `stall`=0 for 5 cycles.
- Non-memory ops at T and T+1 (`in_data` 0x11 then 0x22, x5 then x6, `reg_we`=1) → `wb_valid` at T+1 with 0x11/x5 and at T+2 with 0x22/x6; `stall` stays 0.
- Load from 0x100 to x7, RAM acks at T+3 with 0xDEADBEEF → `ram_req` high T+1..T+3 at address 0x100 with `ram_we`=0; `stall` high T..T+3; at T+4 `wb_valid`=1, `wb_we`=1, `wb_addr`=7, `wb_data`=0xDEADBEEF.
- Store of 0xCAFE to 0x200, ack at T+1 → `ram_we`=1, `ram_wdata`=0xCAFE; `wb_valid` at T+2 with `wb_we`=0 and `wb_err`=0.
- TIMEOUT=4, load with no ack → `ram_req` high T+1..T+4; at T+5 `wb_valid`=1, `wb_err`=1, `wb_we`=0; back in IDLE at T+6.
- `rst` at T+2 during an outstanding load, with an ack at T+3 → `ram_req`=0 at T+3, no `wb_valid` afterwards, and the stray ack is ignored.
